// File: rtl/regfile_arbiter.sv
// Two-requester arbiter for the shared 8x16 register file access port.
// Round-robin per cycle, optional ownership lock bounded by MAX_HOLD.
module regfile_arbiter #(
   parameter int unsigned ADDR_W   = 3,
   parameter int unsigned DATA_W   = 16,
   parameter int unsigned MAX_HOLD = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0,
   input  logic              req1,
   input  logic              lock0,
   input  logic              lock1,
   input  logic              we0,
   input  logic              we1,
   input  logic [ADDR_W-1:0] raddr1_0,
   input  logic [ADDR_W-1:0] raddr1_1,
   input  logic [ADDR_W-1:0] raddr2_0,
   input  logic [ADDR_W-1:0] raddr2_1,
   input  logic [ADDR_W-1:0] waddr0,
   input  logic [ADDR_W-1:0] waddr1,
   input  logic [DATA_W-1:0] wdata0,
   input  logic [DATA_W-1:0] wdata1,
   output logic              gnt0,
   output logic              gnt1,
   output logic              rvalid0,
   output logic              rvalid1,
   output logic [DATA_W-1:0] rdata1,
   output logic [DATA_W-1:0] rdata2,
   output logic [1:0]        preempt,
   output logic              rf_we,
   output logic [ADDR_W-1:0] rf_raddr1,
   output logic [ADDR_W-1:0] rf_raddr2,
   output logic [ADDR_W-1:0] rf_waddr,
   output logic [DATA_W-1:0] rf_wdata,
   input  logic [DATA_W-1:0] rf_rdata1,
   input  logic [DATA_W-1:0] rf_rdata2
);

   localparam int unsigned HCW = $clog2(MAX_HOLD + 1);
   localparam logic [HCW-1:0] HOLD_LIMIT = HCW'(MAX_HOLD);

   typedef enum logic [1:0] {
      IDLE,
      OWN0,
      OWN1
   } state_t;

   state_t           state_q, state_d;
   logic             last_q, last_d;
   logic [HCW-1:0]   hold_q, hold_d;
   logic [1:0]       blocked_q, blocked_d;
   logic [1:0]       rvalid_q;
   logic [1:0]       preempt_q, preempt_d;
   logic [1:0]       gnt;
   logic [1:0]       brk;

   // brk[n]: owner n is still requesting but has used up its hold budget
   always_comb begin
      gnt = '0;
      brk = '0;
      if (rst) begin
         brk[0] = (state_q == OWN0) && req0 && req1 && (hold_q == HOLD_LIMIT);
         brk[1] = (state_q == OWN1) && req1 && req0 && (hold_q == HOLD_LIMIT);
         if ((state_q == OWN0) && req0 && !brk[0]) begin
            gnt = 2'b01;
         end else if ((state_q == OWN1) && req1 && !brk[1]) begin
            gnt = 2'b10;
         end else if (req0 && req1) begin
            gnt = last_q ? 2'b01 : 2'b10;
         end else if (req0) begin
            gnt = 2'b01;
         end else if (req1) begin
            gnt = 2'b10;
         end
      end
   end

   always_comb begin
      state_d   = IDLE;
      hold_d    = '0;
      last_d    = last_q;
      blocked_d = blocked_q & {lock1, lock0};
      preempt_d = brk;

      if (gnt[0]) begin
         last_d = 1'b0;
      end else if (gnt[1]) begin
         last_d = 1'b1;
      end

      // A broken lock always falls back to IDLE, even if the winner asks to lock
      if (|brk) begin
         state_d = IDLE;
      end else if (gnt[0] && lock0 && !blocked_q[0]) begin
         state_d = OWN0;
      end else if (gnt[1] && lock1 && !blocked_q[1]) begin
         state_d = OWN1;
      end

      if (brk[0]) begin
         blocked_d[0] = 1'b1;
      end
      if (brk[1]) begin
         blocked_d[1] = 1'b1;
      end

      if ((state_q == OWN0) && (state_d == OWN0) && req1) begin
         hold_d = hold_q + HCW'(1);
      end else if ((state_q == OWN1) && (state_d == OWN1) && req0) begin
         hold_d = hold_q + HCW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= IDLE;
         last_q    <= 1'b1;
         hold_q    <= '0;
         blocked_q <= '0;
         rvalid_q  <= '0;
         preempt_q <= '0;
      end else begin
         state_q   <= state_d;
         last_q    <= last_d;
         hold_q    <= hold_d;
         blocked_q <= blocked_d;
         rvalid_q  <= gnt;
         preempt_q <= preempt_d;
      end
   end

   always_comb begin
      rf_we     = 1'b0;
      rf_raddr1 = '0;
      rf_raddr2 = '0;
      rf_waddr  = '0;
      rf_wdata  = '0;
      if (gnt[0]) begin
         rf_we     = we0;
         rf_raddr1 = raddr1_0;
         rf_raddr2 = raddr2_0;
         rf_waddr  = waddr0;
         rf_wdata  = wdata0;
      end else if (gnt[1]) begin
         rf_we     = we1;
         rf_raddr1 = raddr1_1;
         rf_raddr2 = raddr2_1;
         rf_waddr  = waddr1;
         rf_wdata  = wdata1;
      end
   end

   assign gnt0    = gnt[0];
   assign gnt1    = gnt[1];
   assign rvalid0 = rvalid_q[0];
   assign rvalid1 = rvalid_q[1];
   assign preempt = preempt_q;
   assign rdata1  = rf_rdata1;
   assign rdata2  = rf_rdata2;

endmodule
